// File: rtl/key_event.sv
// Key event detector: classifies presses as short, long or auto-repeat and latches sticky IRQ status.
// Latency: edge/tick at clk N -> event pulse / pressed at N+1 -> irq_sts bit at N+2.
// Backpressure: none; the block consumes 1-clk pulses every cycle and never stalls.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   en                    block enable; low forces IDLE and suppresses events
//   act_edge, inact_edge  filtered press / release pulses
//   tick                  time-base strobe; all timing is counted in ticks
//   long_th               ticks from press to long event
//   rpt_en, rpt_dly       auto-repeat enable, ticks from long event to first repeat
//   rpt_int               ticks between subsequent repeats
//   irq_mask, irq_clr     per-bit interrupt enable and write-1 clear ([0] short, [1] long, [2] repeat)
//   short_ev, long_ev, rpt_ev  registered 1-clk event pulses
//   pressed               key held (state != IDLE), registered
//   irq_sts, irq          sticky status and masked interrupt
module key_event #(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          act_edge,
    input  logic          inact_edge,
    input  logic          tick,
    input  logic [BW-1:0] long_th,
    input  logic          rpt_en,
    input  logic [BW-1:0] rpt_dly,
    input  logic [BW-1:0] rpt_int,
    input  logic [2:0]    irq_mask,
    input  logic [2:0]    irq_clr,
    output logic          short_ev,
    output logic          long_ev,
    output logic          rpt_ev,
    output logic          pressed,
    output logic [2:0]    irq_sts,
    output logic          irq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_LONG   = 2'd2,
        S_REPEAT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          short_ev_q, short_ev_d;
    logic          long_ev_q, long_ev_d;
    logic          rpt_ev_q, rpt_ev_d;
    logic          pressed_q, pressed_d;
    logic [2:0]    irq_sts_q, irq_sts_d;

    // One extra bit so cnt+1 can never wrap; at cnt = max every threshold
    // is reached, so the counter is always reset before it could overflow.
    logic [BW:0]   cnt_inc;
    logic          hit_long, hit_dly, hit_int;

    assign cnt_inc  = {1'b0, cnt_q} + {{BW{1'b0}}, 1'b1};
    assign hit_long = (cnt_inc >= {1'b0, long_th});
    assign hit_dly  = (cnt_inc >= {1'b0, rpt_dly});
    assign hit_int  = (cnt_inc >= {1'b0, rpt_int});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            short_ev_q <= 1'b0;
            long_ev_q  <= 1'b0;
            rpt_ev_q   <= 1'b0;
            pressed_q  <= 1'b0;
            irq_sts_q  <= 3'b000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            short_ev_q <= short_ev_d;
            long_ev_q  <= long_ev_d;
            rpt_ev_q   <= rpt_ev_d;
            pressed_q  <= pressed_d;
            irq_sts_q  <= irq_sts_d;
        end
    end

    // Next-state and counter. Release outranks tick; disable outranks all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Coincident press and release is a glitch: ignore it.
                    if (act_edge && !inact_edge) begin
                        state_d = S_PRESS;
                        cnt_d   = '0;
                    end
                end
                S_PRESS: begin
                    if (inact_edge) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (hit_long) begin
                            state_d = S_LONG;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[BW-1:0];
                        end
                    end
                end
                S_LONG: begin
                    if (inact_edge) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (!rpt_en) begin
                        cnt_d = '0;
                    end else if (tick) begin
                        if (hit_dly) begin
                            state_d = S_REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[BW-1:0];
                        end
                    end
                end
                S_REPEAT: begin
                    // With repeat disabled the count is frozen until release.
                    if (inact_edge) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (tick && rpt_en) begin
                        cnt_d = hit_int ? '0 : cnt_inc[BW-1:0];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs: event pulses and status, all registered.
    always_comb begin
        short_ev_d = en && (state_q == S_PRESS) && inact_edge;
        long_ev_d  = en && (state_q == S_PRESS) && !inact_edge && tick && hit_long;
        rpt_ev_d   = en && !inact_edge && tick && rpt_en &&
                     (((state_q == S_LONG) && hit_dly) ||
                      ((state_q == S_REPEAT) && hit_int));
        pressed_d  = (state_d != S_IDLE);
        // Set wins over clear on the same bit.
        irq_sts_d  = (irq_sts_q & ~irq_clr) | {rpt_ev_q, long_ev_q, short_ev_q};
    end

    assign short_ev = short_ev_q;
    assign long_ev  = long_ev_q;
    assign rpt_ev   = rpt_ev_q;
    assign pressed  = pressed_q;
    assign irq_sts  = irq_sts_q;
    assign irq      = |(irq_sts_q & irq_mask);

endmodule

// File: tb/tb_key_event.sv
module tb_key_event;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        act_edge, inact_edge, tick;
    logic [15:0] long_th, rpt_dly, rpt_int;
    logic        rpt_en;
    logic [2:0]  irq_mask, irq_clr;
    logic        short_ev, long_ev, rpt_ev, pressed, irq;
    logic [2:0]  irq_sts;

    key_event #(.BW(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .act_edge(act_edge), .inact_edge(inact_edge), .tick(tick),
        .long_th(long_th), .rpt_en(rpt_en), .rpt_dly(rpt_dly), .rpt_int(rpt_int),
        .irq_mask(irq_mask), .irq_clr(irq_clr),
        .short_ev(short_ev), .long_ev(long_ev), .rpt_ev(rpt_ev),
        .pressed(pressed), .irq_sts(irq_sts), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;

    // Observed pulse counts per scenario
    int c_s, c_l, c_r;

    // Reference model: phase 0 idle, 1 held awaiting long, 2 long awaiting
    // first repeat, 3 repeating; m_ticks = ticks counted in the phase.
    int       m_phase;
    int       m_ticks;
    bit       m_s, m_l, m_r;
    bit [2:0] m_sts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ticks = 0;
        m_s = 0; m_l = 0; m_r = 0; m_sts = 3'b000;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clk();
        bit ns, nl, nr;
        int th;
        ns = 0; nl = 0; nr = 0;
        if (!en) begin
            m_phase = 0; m_ticks = 0;
        end else if (m_phase == 0) begin
            if (act_edge && !inact_edge) begin m_phase = 1; m_ticks = 0; end
        end else if (inact_edge) begin
            if (m_phase == 1) ns = 1;
            m_phase = 0; m_ticks = 0;
        end else if (m_phase == 1) begin
            if (tick) begin
                th = int'(long_th);
                if (m_ticks + 1 >= th) begin nl = 1; m_phase = 2; m_ticks = 0; end
                else m_ticks++;
            end
        end else if (!rpt_en) begin
            if (m_phase == 2) m_ticks = 0;
        end else if (tick) begin
            th = (m_phase == 2) ? int'(rpt_dly) : int'(rpt_int);
            if (m_ticks + 1 >= th) begin nr = 1; m_phase = 3; m_ticks = 0; end
            else m_ticks++;
        end
        m_sts = (m_sts & ~irq_clr) | {m_r, m_l, m_s};
        m_s = ns; m_l = nl; m_r = nr;
    endtask

    task automatic check_all();
        chk("short_ev", short_ev, m_s);
        chk("long_ev", long_ev, m_l);
        chk("rpt_ev", rpt_ev, m_r);
        chk("pressed", pressed, m_phase != 0);
        chk("irq_sts", irq_sts, m_sts);
        chk("irq", irq, |(m_sts & irq_mask));
        if (short_ev === 1'b1) c_s++;
        if (long_ev === 1'b1) c_l++;
        if (rpt_ev === 1'b1) c_r++;
    endtask

    task automatic step(input logic a, input logic r, input logic t, input logic [2:0] c);
        act_edge = a; inact_edge = r; tick = t; irq_clr = c;
        model_clk();
        @(posedge clk);
        #1;
        check_all();
        act_edge = 0; inact_edge = 0; tick = 0; irq_clr = 3'b000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'b000);
    endtask

    // Tick every 4 clocks
    task automatic tk();
        idle(3);
        step(0, 0, 1, 3'b000);
    endtask

    task automatic zero_counts();
        c_s = 0; c_l = 0; c_r = 0;
    endtask

    task automatic clear_all();
        idle(2);
        step(0, 0, 0, 3'b111);
        idle(1);
        zero_counts();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_short", short_ev, 1'b0);
        chk("rst_long", long_ev, 1'b0);
        chk("rst_rpt", rpt_ev, 1'b0);
        chk("rst_pressed", pressed, 1'b0);
        chk("rst_sts", irq_sts, 3'b000);
        chk("rst_irq", irq, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        act_edge = 0; inact_edge = 0; tick = 0; irq_clr = 3'b000;
        long_th = 16'd3; rpt_dly = 16'd2; rpt_int = 16'd1; rpt_en = 1'b0;
        irq_mask = 3'b000;
        model_reset(); zero_counts();
        #12;
        chk("reset_short", short_ev, 1'b0);
        chk("reset_long", long_ev, 1'b0);
        chk("reset_rpt", rpt_ev, 1'b0);
        chk("reset_pressed", pressed, 1'b0);
        chk("reset_sts", irq_sts, 3'b000);
        chk("reset_irq", irq, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Short press
        step(1, 0, 0, 3'b000);
        chk("sp_pressed", pressed, 1'b1);
        tk(); tk(); idle(3);
        step(0, 1, 0, 3'b000);
        chk("sp_short_now", short_ev, 1'b1);
        chk("sp_pressed_drop", pressed, 1'b0);
        idle(3);
        chk("sp_short_cnt", c_s, 1);
        chk("sp_long_cnt", c_l, 0);
        chk("sp_sts", irq_sts, 3'b001);
        irq_mask = 3'b010;
        #1;
        chk("sp_irq_masked", irq, 1'b0);
        step(0, 0, 0, 3'b001);
        idle(1);
        zero_counts();

        // Long press, no repeat
        rpt_en = 1'b0;
        step(1, 0, 0, 3'b000);
        for (int k = 1; k <= 10; k++) begin
            tk();
            if (k == 3) chk("lp_long_t3", long_ev, 1'b1);
        end
        idle(2);
        step(0, 1, 0, 3'b000);
        idle(3);
        chk("lp_long_cnt", c_l, 1);
        chk("lp_short_cnt", c_s, 0);
        chk("lp_sts", irq_sts, 3'b010);
        chk("lp_irq", irq, 1'b1);

        // Clear collides with a second long event: set wins
        step(1, 0, 0, 3'b000);
        tk(); tk(); tk();
        chk("col_long", long_ev, 1'b1);
        step(0, 0, 0, 3'b010);
        chk("col_sts_kept", irq_sts[1], 1'b1);
        idle(2);
        step(0, 1, 0, 3'b000);
        idle(2);
        step(0, 0, 0, 3'b010);
        chk("col_sts_clr", irq_sts[1], 1'b0);
        chk("col_irq_clr", irq, 1'b0);
        clear_all();

        // Auto-repeat
        long_th = 16'd3; rpt_dly = 16'd2; rpt_int = 16'd1; rpt_en = 1'b1;
        step(1, 0, 0, 3'b000);
        for (int k = 1; k <= 8; k++) tk();
        idle(1);
        step(0, 1, 0, 3'b000);
        idle(3);
        chk("ar_long_cnt", c_l, 1);
        chk("ar_rpt_cnt", c_r, 4);
        chk("ar_sts", irq_sts, 3'b110);
        clear_all();

        // Release coincident with the 3rd tick
        step(1, 0, 0, 3'b000);
        tk(); tk(); idle(3);
        step(0, 1, 1, 3'b000);
        idle(2);
        chk("co_short_cnt", c_s, 1);
        chk("co_long_cnt", c_l, 0);
        clear_all();

        // long_th = 0 fires on the first tick
        long_th = 16'd0; rpt_en = 1'b0;
        step(1, 0, 0, 3'b000);
        tk();
        chk("th0_long", long_ev, 1'b1);
        step(0, 1, 0, 3'b000);
        clear_all();

        // Lowering long_th mid-count
        long_th = 16'd10;
        step(1, 0, 0, 3'b000);
        for (int k = 0; k < 5; k++) tk();
        chk("lower_no_long_yet", c_l, 0);
        long_th = 16'd2;
        tk();
        chk("lower_long", long_ev, 1'b1);
        step(0, 1, 0, 3'b000);
        clear_all();

        // Disable during a hold
        long_th = 16'd3;
        step(1, 0, 0, 3'b000);
        tk(); idle(3);
        en = 1'b0;
        step(0, 0, 1, 3'b000);
        chk("dis_pressed", pressed, 1'b0);
        en = 1'b1;
        for (int k = 0; k < 4; k++) tk();
        step(0, 1, 0, 3'b000);
        idle(2);
        chk("dis_long_cnt", c_l, 0);
        chk("dis_short_cnt", c_s, 0);
        clear_all();

        // Reset mid-REPEAT
        long_th = 16'd1; rpt_dly = 16'd1; rpt_int = 16'd2; rpt_en = 1'b1;
        step(1, 0, 0, 3'b000);
        tk(); tk(); tk();
        idle(1);
        chk("rr_in_repeat", pressed, 1'b1);
        do_reset();
        idle(3);
        chk("rr_pressed_after", pressed, 1'b0);

        // Randomized run against the model
        zero_counts();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 99) == 0) begin
                long_th = 16'($urandom_range(0, 6));
                rpt_dly = 16'($urandom_range(0, 4));
                rpt_int = 16'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 79) == 0) rpt_en = ~rpt_en;
            if ($urandom_range(0, 49) == 0) irq_mask = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 14) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Key/button event detector. Sits directly downstream of the digital noise filter and consumes its 1-clk active-edge and inactive-edge pulses.
- Classifies each press as short press, long press, or auto-repeat using a tick-based time counter and a 4-state FSM.
- Latches events into sticky, maskable interrupt status bits for the GPIO/peripheral register block.

Parameters:
- BW, 16, time counter and threshold width in bits.

Ports:
- clk  input  1  Global clock; single clock domain.
- rst  input  1  Global reset. Reset is asynchronous and active-high.
- en  input  1  Block enable; 0 forces IDLE and suppresses events.
- act_edge  input  1  Filtered active-edge pulse, 1 clk (press).
- inact_edge  input  1  Filtered inactive-edge pulse, 1 clk (release).
- tick  input  1  Time-base strobe, 1 clk wide; all timing is counted in ticks.
- long_th  input  BW  Ticks from press to long event.
- rpt_en  input  1  Auto-repeat enable.
- rpt_dly  input  BW  Ticks from long event to first repeat.
- rpt_int  input  BW  Ticks between subsequent repeats.
- irq_mask  input  3  Interrupt enable per status bit: [0] short, [1] long, [2] repeat.
- irq_clr  input  3  Write-1 clear per status bit, 1-clk pulse.
- short_ev  output  1  Short-press event pulse, registered.
- long_ev  output  1  Long-press event pulse, registered.
- rpt_ev  output  1  Repeat event pulse, registered.
- pressed  output  1  Key-held status (state != IDLE), registered.
- irq_sts  output  3  Sticky event status.
- irq  output  1  OR of (irq_sts & irq_mask), combinational from registers.

Behaviour:
- Reset: state=IDLE, cnt=0. short_ev, long_ev, rpt_ev, pressed, irq_sts and irq are all 0.
- All event outputs are registered. Each pulse is high exactly 1 clk, in the cycle after the triggering edge or tick.
- FSM states: IDLE, PRESS, LONG, REPEAT. The cnt register (BW bits) is cleared on every state entry.
- Threshold rule: a threshold is reached when cnt+1 >= th on a tick. th=0 and th=1 both fire on the first tick. Lowering th mid-count below cnt fires on the next tick. cnt never wraps.
- IDLE:
  - act_edge & en -> PRESS.
  - inact_edge is ignored.
- PRESS:
  - inact_edge -> short_ev, then IDLE.
  - tick reaching long_th -> long_ev, then LONG.
  - Any other tick -> cnt+1.
- LONG:
  - inact_edge -> IDLE; no event.
  - tick & rpt_en reaching rpt_dly -> rpt_ev, then REPEAT.
  - tick & rpt_en otherwise -> cnt+1.
  - rpt_en=0 -> cnt held at 0.
- REPEAT:
  - inact_edge -> IDLE.
  - tick reaching rpt_int -> rpt_ev, cnt=0, stay in REPEAT.
  - rpt_en=0 -> IDLE wait: stay in REPEAT, hold cnt, no rpt_ev.
- act_edge in any non-IDLE state is ignored.
- Same-cycle inact_edge and tick: release has priority. In PRESS this gives short_ev and no long_ev.
- Same-cycle act_edge and inact_edge: treated as a glitch. In IDLE it is ignored (stay IDLE). In other states inact_edge wins -> IDLE.
- en=0 in any state -> IDLE next clk, cnt=0, no event pulses generated.
  - If en rises while the key is held, no press is detected until the next act_edge.
- pressed=1 for the clk after entry to PRESS through the clk of the return to IDLE (registered alongside state).
- irq_sts[i] is set by its event pulse and cleared by irq_clr[i]. Set wins over clear in the same cycle. Bits are independent.
- Latency: act_edge at clk N -> pressed=1 at N+1. Qualifying tick at clk M -> event pulse at M+1, irq_sts bit at M+2.
- Asynchronous rst mid-operation returns every register to its reset value immediately. No event is emitted on reset release.

Test Plan:
- Short press: long_th=3, tick every 4 clk; act_edge, 2 ticks, inact_edge -> exactly one short_ev 1 clk after inact_edge; long_ev=0; irq_sts=3'b001; pressed high for the hold duration.
- Long press, no repeat: long_th=3, rpt_en=0; hold for 10 ticks -> long_ev once, 1 clk after the 3rd tick; release -> no short_ev; irq_sts=3'b010.
- Auto-repeat: long_th=3, rpt_dly=2, rpt_int=1, rpt_en=1; hold for 8 ticks then release -> long_ev after tick 3, rpt_ev after ticks 5, 6, 7, 8 (4 pulses); irq_sts=3'b110.
- Boundaries:
  - inact_edge coincident with the 3rd tick (long_th=3) -> short_ev only.
  - long_th=0 -> long_ev on the first tick.
  - Lowering long_th from 10 to 2 at cnt=5 -> long_ev on the next tick.
- IRQ: irq_mask=3'b010 after the short-press scenario -> irq=0; long press -> irq=1.
  - irq_clr=3'b010 in the same cycle as a second long_ev -> bit remains 1.
  - A later clr with no event -> bit 0, irq=0.
- Disable/reset: drop en at tick 2 of a hold (long_th=3) -> IDLE next clk, no long_ev, no short_ev on release.
  - Assert rst mid-REPEAT -> all outputs 0 asynchronously, state IDLE after release.
